// File: rtl/branch_resolution_unit_pkg.sv
// Shared types for the branch resolution unit: the branch direction encoding and
// the in-flight entry that is held between decode and EX.
package branch_resolution_unit_pkg;

    localparam int BRU_DEPTH      = 4;
    localparam int BRU_ADDR_WIDTH = 32;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    typedef struct packed {
        logic [BRU_ADDR_WIDTH-1:0] pc;
        logic [BRU_ADDR_WIDTH-1:0] recovery_target;
        BranchOutcome              prediction;
    } branch_inflight_t;

endpackage

// File: rtl/branch_resolution_unit_inflight_fifo.sv
// In-order queue of predicted branches awaiting resolution. A flush empties the
// queue and takes priority over any push in the same cycle.
module branch_inflight_fifo #(
    parameter int DATA_W = 65,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [DATA_W-1:0]        i_data,
    output logic [DATA_W-1:0]        o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    assign w_push  = i_push & ~o_full & ~i_flush;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked solely by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/branch_resolution_unit.sv
// EX-side branch resolution: pops the oldest predicted branch, reports feedback to
// the predictor, redirects fetch on a mispredict and keeps saturating statistics.
module branch_resolution_unit
    import branch_resolution_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = BRU_ADDR_WIDTH,
    parameter int DEPTH      = BRU_DEPTH,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_pred_valid,
    input  logic [ADDR_WIDTH-1:0] i_pred_pc,
    input  BranchOutcome          i_pred_prediction,
    input  logic [ADDR_WIDTH-1:0] i_pred_recovery_target,
    output logic                  o_pred_ready,
    input  logic                  i_ex_valid,
    input  logic [ADDR_WIDTH-1:0] i_ex_pc,
    input  BranchOutcome          i_ex_outcome,
    output logic                  o_fb_valid,
    output logic [ADDR_WIDTH-1:0] o_fb_pc,
    output BranchOutcome          o_fb_prediction,
    output BranchOutcome          o_fb_outcome,
    output logic                  o_redirect_valid,
    output logic [ADDR_WIDTH-1:0] o_redirect_pc,
    output logic                  o_err,
    output logic [CNT_WIDTH-1:0]  o_branch_count,
    output logic [CNT_WIDTH-1:0]  o_miss_count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    branch_inflight_t w_push_entry;
    branch_inflight_t w_head;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic             w_push;
    logic             w_pop;
    logic             w_miss;
    logic             w_err_evt;

    logic                  r_fb_valid;
    logic [ADDR_WIDTH-1:0] r_fb_pc;
    BranchOutcome          r_fb_prediction;
    BranchOutcome          r_fb_outcome;
    logic                  r_redirect_valid;
    logic [ADDR_WIDTH-1:0] r_redirect_pc;
    logic                  r_err;
    logic [CNT_WIDTH-1:0]  r_branch_count;
    logic [CNT_WIDTH-1:0]  r_miss_count;

    assign w_push_entry = '{pc:              i_pred_pc,
                            recovery_target: i_pred_recovery_target,
                            prediction:      i_pred_prediction};

    // Ready depends only on the registered occupancy, never on this cycle's pop.
    assign o_pred_ready = (w_count != CNT_W'(DEPTH));
    assign w_push       = i_pred_valid & ~w_full;
    assign w_pop        = i_ex_valid & ~w_empty;
    assign w_miss       = w_pop & (w_head.prediction != i_ex_outcome);
    assign w_err_evt    = i_ex_valid & (w_empty | (w_head.pc != i_ex_pc));

    branch_inflight_fifo #(
        .DATA_W ($bits(branch_inflight_t)),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_miss),
        .i_data  (w_push_entry),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fb_valid       <= 1'b0;
            r_fb_pc          <= '0;
            r_fb_prediction  <= NOT_TAKEN;
            r_fb_outcome     <= NOT_TAKEN;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_err            <= 1'b0;
            r_branch_count   <= '0;
            r_miss_count     <= '0;
        end else begin
            r_fb_valid       <= w_pop;
            r_fb_pc          <= w_pop ? w_head.pc : '0;
            r_fb_prediction  <= w_pop ? w_head.prediction : NOT_TAKEN;
            r_fb_outcome     <= w_pop ? i_ex_outcome : NOT_TAKEN;
            r_redirect_valid <= w_miss;
            r_redirect_pc    <= w_miss ? w_head.recovery_target : '0;
            if (w_err_evt) r_err <= 1'b1;
            if (w_pop)     r_branch_count <= sat_inc(r_branch_count);
            if (w_miss)    r_miss_count   <= sat_inc(r_miss_count);
        end
    end

    assign o_fb_valid       = r_fb_valid;
    assign o_fb_pc          = r_fb_pc;
    assign o_fb_prediction  = r_fb_prediction;
    assign o_fb_outcome     = r_fb_outcome;
    assign o_redirect_valid = r_redirect_valid;
    assign o_redirect_pc    = r_redirect_pc;
    assign o_err            = r_err;
    assign o_branch_count   = r_branch_count;
    assign o_miss_count     = r_miss_count;

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Directed bench for branch_resolution_unit: expected feedback is queued when a
// resolve is issued and checked by a monitor whenever the DUT emits feedback.
module tb_branch_resolution_unit;
    import branch_resolution_unit_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         pred_valid;
    logic [31:0]  pred_pc;
    BranchOutcome pred_prediction;
    logic [31:0]  pred_rtgt;
    logic         pred_ready;
    logic         ex_valid;
    logic [31:0]  ex_pc;
    BranchOutcome ex_outcome;
    logic         fb_valid;
    logic [31:0]  fb_pc;
    BranchOutcome fb_prediction;
    BranchOutcome fb_outcome;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic         err;
    logic [31:0]  branch_count;
    logic [31:0]  miss_count;

    typedef struct {
        logic [31:0]  pc;
        BranchOutcome pred;
        BranchOutcome out;
        logic         redir;
        logic [31:0]  rpc;
        logic [31:0]  bc;
        logic [31:0]  mc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    branch_resolution_unit #(.ADDR_WIDTH(32), .DEPTH(4), .CNT_WIDTH(32)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .i_pred_valid           (pred_valid),
        .i_pred_pc              (pred_pc),
        .i_pred_prediction      (pred_prediction),
        .i_pred_recovery_target (pred_rtgt),
        .o_pred_ready           (pred_ready),
        .i_ex_valid             (ex_valid),
        .i_ex_pc                (ex_pc),
        .i_ex_outcome           (ex_outcome),
        .o_fb_valid             (fb_valid),
        .o_fb_pc                (fb_pc),
        .o_fb_prediction        (fb_prediction),
        .o_fb_outcome           (fb_outcome),
        .o_redirect_valid       (redirect_valid),
        .o_redirect_pc          (redirect_pc),
        .o_err                  (err),
        .o_branch_count         (branch_count),
        .o_miss_count           (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        pred_valid      = 1'b0;
        pred_pc         = '0;
        pred_prediction = NOT_TAKEN;
        pred_rtgt       = '0;
        ex_valid        = 1'b0;
        ex_pc           = '0;
        ex_outcome      = NOT_TAKEN;
    endtask

    // Drive one cycle of stimulus (called just after a falling edge).
    task automatic cyc(input logic pv, input logic [31:0] ppc, input BranchOutcome ppred,
                       input logic [31:0] prt, input logic ev, input logic [31:0] epc,
                       input BranchOutcome eout);
        pred_valid      = pv;
        pred_pc         = ppc;
        pred_prediction = ppred;
        pred_rtgt       = prt;
        ex_valid        = ev;
        ex_pc           = epc;
        ex_outcome      = eout;
        @(negedge clk);
        idle();
    endtask

    task automatic push(input logic [31:0] pc, input BranchOutcome p, input logic [31:0] rt);
        cyc(1'b1, pc, p, rt, 1'b0, 32'h0, NOT_TAKEN);
    endtask

    task automatic resolve(input logic [31:0] pc, input BranchOutcome o);
        cyc(1'b0, 32'h0, NOT_TAKEN, 32'h0, 1'b1, pc, o);
    endtask

    task automatic expect_fb(input logic [31:0] pc, input BranchOutcome p, input BranchOutcome o,
                             input logic rd, input logic [31:0] rpc, input logic [31:0] bc,
                             input logic [31:0] mc);
        exp_t e;
        e.pc = pc; e.pred = p; e.out = o; e.redir = rd; e.rpc = rpc; e.bc = bc; e.mc = mc;
        sb.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (fb_valid || redirect_valid)) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_feedback: got fb_pc=0x%0h redirect=%0b, expected no feedback",
                             fb_pc, redirect_valid);
                end else begin
                    e = sb.pop_front();
                    chk("fb_valid", 64'(fb_valid), 64'd1);
                    chk("fb_pc", 64'(fb_pc), 64'(e.pc));
                    chk("fb_prediction", 64'(fb_prediction), 64'(e.pred));
                    chk("fb_outcome", 64'(fb_outcome), 64'(e.out));
                    chk("redirect_valid", 64'(redirect_valid), 64'(e.redir));
                    chk("redirect_pc", 64'(redirect_pc), 64'(e.rpc));
                    chk("branch_count", 64'(branch_count), 64'(e.bc));
                    chk("miss_count", 64'(miss_count), 64'(e.mc));
                end
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_fb_valid"}, 64'(fb_valid), 64'd0);
        chk({tag, "_fb_pc"}, 64'(fb_pc), 64'd0);
        chk({tag, "_fb_pred"}, 64'(fb_prediction), 64'd0);
        chk({tag, "_fb_out"}, 64'(fb_outcome), 64'd0);
        chk({tag, "_redirect"}, 64'(redirect_valid), 64'd0);
        chk({tag, "_redirect_pc"}, 64'(redirect_pc), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_branch_count"}, 64'(branch_count), 64'd0);
        chk({tag, "_miss_count"}, 64'(miss_count), 64'd0);
        chk({tag, "_ready"}, 64'(pred_ready), 64'd1);
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        fork
            monitor();
            begin
                #200000;
                $display("FAIL watchdog: got timeout, expected completion");
                $fatal(1, "watchdog expired");
            end
        join_none
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;

        // Correct prediction
        push(32'h100, TAKEN, 32'h108);
        cyc(1'b0, 32'h0, NOT_TAKEN, 32'h0, 1'b0, 32'h0, NOT_TAKEN);
        expect_fb(32'h100, TAKEN, TAKEN, 1'b0, 32'h0, 32'd1, 32'd0);
        resolve(32'h100, TAKEN);
        chk("correct_err", 64'(err), 64'd0);
        cyc(1'b0, 32'h0, NOT_TAKEN, 32'h0, 1'b0, 32'h0, NOT_TAKEN);
        chk("fb_is_pulse", 64'(fb_valid), 64'd0);

        // Mispredict flushes queue and drops the concurrent push
        push(32'h100, NOT_TAKEN, 32'h200);
        push(32'h104, TAKEN, 32'h300);
        push(32'h108, TAKEN, 32'h400);
        expect_fb(32'h100, NOT_TAKEN, TAKEN, 1'b1, 32'h200, 32'd2, 32'd1);
        cyc(1'b1, 32'h10C, TAKEN, 32'h500, 1'b1, 32'h100, TAKEN);
        chk("miss_ready", 64'(pred_ready), 64'd1);
        chk("miss_err_clear", 64'(err), 64'd0);
        resolve(32'h10C, TAKEN);
        chk("empty_pop_err", 64'(err), 64'd1);
        chk("empty_pop_no_fb", 64'(fb_valid), 64'd0);

        // Reset mid-flight with three entries and err set
        push(32'h300, TAKEN, 32'h0);
        push(32'h304, TAKEN, 32'h0);
        push(32'h308, TAKEN, 32'h0);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_state("midreset");
        rst_n = 1'b1;
        resolve(32'h300, TAKEN);
        chk("post_reset_empty_err", 64'(err), 64'd1);
        chk("post_reset_no_fb", 64'(fb_valid), 64'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Full queue, ignored fifth push, order across pointer wrap
        for (int i = 0; i < 4; i++) begin
            push(32'hA0 + 32'(4 * i), TAKEN, 32'h800 + 32'(4 * i));
            chk($sformatf("fill_ready_%0d", i), 64'(pred_ready), (i < 3) ? 64'd1 : 64'd0);
        end
        push(32'hB0, TAKEN, 32'h880);
        chk("full_ready", 64'(pred_ready), 64'd0);
        expect_fb(32'hA0, TAKEN, TAKEN, 1'b0, 32'h0, 32'd1, 32'd0);
        resolve(32'hA0, TAKEN);
        chk("after_pop_ready", 64'(pred_ready), 64'd1);
        push(32'hB4, NOT_TAKEN, 32'h900);
        chk("refill_ready", 64'(pred_ready), 64'd0);
        for (int i = 1; i < 4; i++) begin
            expect_fb(32'hA0 + 32'(4 * i), TAKEN, TAKEN, 1'b0, 32'h0, 32'(1 + i), 32'd0);
            resolve(32'hA0 + 32'(4 * i), TAKEN);
        end
        expect_fb(32'hB4, NOT_TAKEN, NOT_TAKEN, 1'b0, 32'h0, 32'd5, 32'd0);
        resolve(32'hB4, NOT_TAKEN);
        chk("wrap_err", 64'(err), 64'd0);

        // Simultaneous correct push and pop keeps occupancy
        push(32'hC0, TAKEN, 32'h0);
        push(32'hC4, NOT_TAKEN, 32'h0);
        expect_fb(32'hC0, TAKEN, TAKEN, 1'b0, 32'h0, 32'd6, 32'd0);
        cyc(1'b1, 32'hC8, TAKEN, 32'h0, 1'b1, 32'hC0, TAKEN);
        chk("pushpop_ready", 64'(pred_ready), 64'd1);
        push(32'hCC, TAKEN, 32'h0);
        chk("count3_ready", 64'(pred_ready), 64'd1);
        push(32'hD0, TAKEN, 32'h0);
        chk("count4_ready", 64'(pred_ready), 64'd0);
        expect_fb(32'hC4, NOT_TAKEN, NOT_TAKEN, 1'b0, 32'h0, 32'd7, 32'd0);
        resolve(32'hC4, NOT_TAKEN);
        expect_fb(32'hC8, TAKEN, TAKEN, 1'b0, 32'h0, 32'd8, 32'd0);
        resolve(32'hC8, TAKEN);
        expect_fb(32'hCC, TAKEN, TAKEN, 1'b0, 32'h0, 32'd9, 32'd0);
        resolve(32'hCC, TAKEN);
        expect_fb(32'hD0, TAKEN, TAKEN, 1'b0, 32'h0, 32'd10, 32'd0);
        resolve(32'hD0, TAKEN);
        chk("order_err", 64'(err), 64'd0);

        // PC mismatch still pops and reports the head entry
        push(32'h100, TAKEN, 32'h108);
        expect_fb(32'h100, TAKEN, TAKEN, 1'b0, 32'h0, 32'd11, 32'd0);
        resolve(32'h104, TAKEN);
        chk("pc_mismatch_err", 64'(err), 64'd1);

        cyc(1'b0, 32'h0, NOT_TAKEN, 32'h0, 1'b0, 32'h0, NOT_TAKEN);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
